// File: rtl/unsi_multiplier_16bit_if.sv
// ---------------------------------------------------------------------------
// unsi_multiplier_16bit_if
//
// Request/response bundle for the sequential shift-add unsigned multiplier.
//
// Signals:
//   start_multiply  requester -> multiplier  request a new multiplication
//   input_1         requester -> multiplier  multiplicand (WIDTH bits)
//   input_2         requester -> multiplier  multiplier   (WIDTH bits)
//   output_P        multiplier -> requester  registered product (2*WIDTH bits)
//   output_ready    multiplier -> requester  output_P holds the latest result
//   busy            multiplier -> requester  multiplication in progress
//   zero            multiplier -> requester  registered "product is zero" flag
//
// Modports:
//   master  the side that issues operands and consumes the product
//   slave   the multiplier itself
// ---------------------------------------------------------------------------
interface unsi_multiplier_16bit_if #(
    parameter int WIDTH = 16
) ();

    logic                   start_multiply;
    logic [WIDTH-1:0]       input_1;
    logic [WIDTH-1:0]       input_2;
    logic [2*WIDTH-1:0]     output_P;
    logic                   output_ready;
    logic                   busy;
    logic                   zero;

    modport master (
        output start_multiply,
        output input_1,
        output input_2,
        input  output_P,
        input  output_ready,
        input  busy,
        input  zero
    );

    modport slave (
        input  start_multiply,
        input  input_1,
        input  input_2,
        output output_P,
        output output_ready,
        output busy,
        output zero
    );

endinterface

// File: rtl/unsi_multiplier_16bit.sv
// ---------------------------------------------------------------------------
// unsi_multiplier_16bit
//
// Sequential shift-add unsigned multiplier. Produces the full 2*WIDTH-bit
// product of two WIDTH-bit operands, retiring one multiplier bit per clock.
// A start is accepted in IDLE or DONE; WIDTH clocks later the product, the
// zero flag and output_ready are written on the same edge that busy falls.
// The result is then held in DONE until the next accepted start.
//
// Parameters:
//   WIDTH      operand width in bits
//   LOG_WIDTH  iteration counter width, 2**LOG_WIDTH >= WIDTH
//
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   mul_bus  slave side of unsi_multiplier_16bit_if
//            (start_multiply, input_1, input_2 in;
//             output_P, output_ready, busy, zero out)
// ---------------------------------------------------------------------------
module unsi_multiplier_16bit #(
    parameter int WIDTH     = 16,
    parameter int LOG_WIDTH = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    unsi_multiplier_16bit_if.slave  mul_bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LOG_WIDTH-1:0] LAST_COUNT = LOG_WIDTH'(WIDTH - 1);

    state_t                 state;
    state_t                 state_next;

    logic [WIDTH-1:0]       mcand;
    logic [WIDTH-1:0]       mcand_next;
    logic [WIDTH-1:0]       mult;
    logic [WIDTH-1:0]       mult_next;
    logic [WIDTH:0]         acc;
    logic [WIDTH:0]         acc_next;
    logic [LOG_WIDTH-1:0]   counter;
    logic [LOG_WIDTH-1:0]   counter_next;

    logic [2*WIDTH-1:0]     product;
    logic [2*WIDTH-1:0]     product_next;
    logic                   ready;
    logic                   ready_next;
    logic                   busy_r;
    logic                   busy_next;
    logic                   zero_r;
    logic                   zero_next;

    logic [WIDTH:0]         addend;
    logic [WIDTH:0]         sum;
    logic [2*WIDTH-1:0]     shifted;
    logic                   last_iter;

    // Partial-product datapath. acc never exceeds WIDTH significant bits
    // after a shift, so a WIDTH+1-bit sum always holds the carry out.
    // Shifting {acc, mult} right by one drops mult[0] (already consumed)
    // and moves sum[0] into the top of mult; the full register after the
    // shift is therefore {sum, mult[WIDTH-1:1]}.
    always_comb begin
        addend    = mult[0] ? {1'b0, mcand} : '0;
        sum       = acc + addend;
        shifted   = {sum, mult[WIDTH-1:1]};
        last_iter = (counter == LAST_COUNT);
    end

    // Next-state and next-register logic. Every register holds by default;
    // only an accepted start or a CALC iteration changes anything.
    always_comb begin
        state_next   = state;
        mcand_next   = mcand;
        mult_next    = mult;
        acc_next     = acc;
        counter_next = counter;
        product_next = product;
        ready_next   = ready;
        busy_next    = busy_r;
        zero_next    = zero_r;

        case (state)
            IDLE, DONE: begin
                if (mul_bus.start_multiply) begin
                    mcand_next   = mul_bus.input_1;
                    mult_next    = mul_bus.input_2;
                    acc_next     = '0;
                    counter_next = '0;
                    busy_next    = 1'b1;
                    ready_next   = 1'b0;
                    state_next   = CALC;
                end
            end

            CALC: begin
                acc_next     = {1'b0, sum[WIDTH:1]};
                mult_next    = {sum[0], mult[WIDTH-1:1]};
                counter_next = counter + 1'b1;
                if (last_iter) begin
                    product_next = shifted;
                    zero_next    = (shifted == '0);
                    ready_next   = 1'b1;
                    busy_next    = 1'b0;
                    counter_next = '0;
                    state_next   = DONE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and output registers. A reset mid-calculation discards the
    // partial product; nothing is ever flagged ready without a new start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand   <= '0;
            mult    <= '0;
            acc     <= '0;
            counter <= '0;
            product <= '0;
            ready   <= 1'b0;
            busy_r  <= 1'b0;
            zero_r  <= 1'b0;
        end else begin
            mcand   <= mcand_next;
            mult    <= mult_next;
            acc     <= acc_next;
            counter <= counter_next;
            product <= product_next;
            ready   <= ready_next;
            busy_r  <= busy_next;
            zero_r  <= zero_next;
        end
    end

    assign mul_bus.output_P     = product;
    assign mul_bus.output_ready = ready;
    assign mul_bus.busy         = busy_r;
    assign mul_bus.zero         = zero_r;

endmodule
